// File: rtl/pp_red_box_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_red_box_tracker_pkg
// Description : Pixel-pipeline constants shared by the pp_ blocks. It holds
//               the default active-video geometry and the two-state tracker
//               encoding (WAIT_SOF = 0, ACCUM = 1).
// Revision    : 1.0 - initial release
// ============================================================================
package pp_red_box_tracker_pkg;

    localparam int unsigned c_H_ACTIVE_DEFAULT = 640;
    localparam int unsigned c_V_ACTIVE_DEFAULT = 480;

    typedef logic [0:0] state_t;

    localparam state_t c_WAIT_SOF = 1'b0;
    localparam state_t c_ACCUM    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pp_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : pp_raster_counter
// Description : Holds the raster position (x,y) of the next pixel to arrive.
//               i_step advances the position by one pixel and wraps at the end
//               of each line and frame. i_restart makes the current beat count
//               as (0,0), so the position that follows it is (1,0).
// Ports       : i_clk, i_rstn      - clock, async active-low reset
//               i_step             - a pixel is consumed this cycle
//               i_restart          - treat the consumed pixel as (0,0)
//               o_x, o_y           - position of the next pixel
//               o_last_pixel       - o_x/o_y is the final pixel of a frame
//               o_at_origin        - o_x/o_y is (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module pp_raster_counter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned XW       = $clog2(H_ACTIVE),
    parameter int unsigned YW       = $clog2(V_ACTIVE)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_step,
    input  logic          i_restart,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last_pixel,
    output logic          o_at_origin
);

    localparam logic [XW-1:0] c_X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(V_ACTIVE - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_cur_x;
    logic [YW-1:0] w_cur_y;

    assign w_cur_x = i_restart ? '0 : r_x;
    assign w_cur_y = i_restart ? '0 : r_y;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (w_cur_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (w_cur_y == c_Y_LAST) ? '0 : w_cur_y + 1'b1;
            end else begin
                r_x <= w_cur_x + 1'b1;
                r_y <= w_cur_y;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_last_pixel = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign o_at_origin  = (r_x == '0) && (r_y == '0);

endmodule
`default_nettype wire

// File: rtl/pp_red_box_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pp_red_box_tracker
// Description : Accumulates the bounding box and the count of red pixels over
//               each frame of the red-detector flag stream. It publishes one
//               result record per completed frame. An i_sof that arrives away
//               from (0,0) aborts the frame and raises o_sync_err.
// Ports       : i_clk, i_rstn        - pixel clock, async active-low reset
//               i_valid              - pixel beat strobe
//               i_pixel_is_red       - red flag for the beat
//               i_sof                - beat is pixel (0,0)
//               o_box_valid          - 1-cycle pulse, result fields updated
//               o_found              - last frame count >= MIN_COUNT
//               o_x_min/o_x_max      - box columns (0 when not found)
//               o_y_min/o_y_max      - box rows (0 when not found)
//               o_red_count          - red pixels in last frame
//               o_sync_err           - 1-cycle pulse, frame aborted
// Revision    : 1.0 - initial release
// ============================================================================
module pp_red_box_tracker
    import pp_red_box_tracker_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = c_H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE  = c_V_ACTIVE_DEFAULT,
    parameter int unsigned MIN_COUNT = 16,
    parameter int unsigned XW        = $clog2(H_ACTIVE),
    parameter int unsigned YW        = $clog2(V_ACTIVE),
    parameter int unsigned CW        = $clog2(H_ACTIVE * V_ACTIVE + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    input  logic          i_pixel_is_red,
    input  logic          i_sof,
    output logic          o_box_valid,
    output logic          o_found,
    output logic [XW-1:0] o_x_min,
    output logic [XW-1:0] o_x_max,
    output logic [YW-1:0] o_y_min,
    output logic [YW-1:0] o_y_max,
    output logic [CW-1:0] o_red_count,
    output logic          o_sync_err
);

    state_t        r_state;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_last_pixel;
    logic          w_at_origin;

    // Accumulators for the frame in progress
    logic          r_any_red;
    logic [CW-1:0] r_count;
    logic [XW-1:0] r_acc_x_min, r_acc_x_max;
    logic [YW-1:0] r_acc_y_min, r_acc_y_max;

    // Published results
    logic          r_box_valid, r_sync_err, r_found;
    logic [XW-1:0] r_res_x_min, r_res_x_max;
    logic [YW-1:0] r_res_y_min, r_res_y_max;
    logic [CW-1:0] r_res_count;

    logic          w_in_accum;
    logic          w_sof_beat;
    logic          w_restart;
    logic          w_proc;
    logic          w_sync_err;
    logic          w_frame_end;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic          w_base_any;
    logic [CW-1:0] w_base_count;
    logic          w_nxt_any;
    logic [CW-1:0] w_nxt_count;
    logic [XW-1:0] w_nxt_x_min, w_nxt_x_max;
    logic [YW-1:0] w_nxt_y_min, w_nxt_y_max;
    logic          w_nxt_found;

    assign w_in_accum  = (r_state == c_ACCUM);
    assign w_sof_beat  = i_valid & i_sof;
    // A sof beat starts a frame from scratch unless it lands on (0,0) of a
    // frame that is already being tracked.
    assign w_restart   = w_sof_beat & (~w_in_accum | ~w_at_origin);
    assign w_sync_err  = w_sof_beat & w_in_accum & ~w_at_origin;
    assign w_proc      = i_valid & (w_in_accum | i_sof);
    assign w_frame_end = w_proc & w_last_pixel & ~w_restart;

    pp_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_raster (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_step       (w_proc),
        .i_restart    (w_restart),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_last_pixel (w_last_pixel),
        .o_at_origin  (w_at_origin)
    );

    // A restarted beat sees position (0,0) and empty accumulators.
    assign w_px         = w_restart ? '0 : w_x;
    assign w_py         = w_restart ? '0 : w_y;
    assign w_base_any   = r_any_red & ~w_restart;
    assign w_base_count = w_restart ? '0 : r_count;

    always_comb begin
        w_nxt_any   = w_base_any;
        w_nxt_count = w_base_count;
        w_nxt_x_min = r_acc_x_min;
        w_nxt_x_max = r_acc_x_max;
        w_nxt_y_min = r_acc_y_min;
        w_nxt_y_max = r_acc_y_max;
        if (i_pixel_is_red) begin
            w_nxt_any   = 1'b1;
            w_nxt_count = w_base_count + 1'b1;
            if (!w_base_any) begin
                w_nxt_x_min = w_px;
                w_nxt_x_max = w_px;
                w_nxt_y_min = w_py;
                w_nxt_y_max = w_py;
            end else begin
                if (w_px < r_acc_x_min) w_nxt_x_min = w_px;
                if (w_px > r_acc_x_max) w_nxt_x_max = w_px;
                if (w_py < r_acc_y_min) w_nxt_y_min = w_py;
                if (w_py > r_acc_y_max) w_nxt_y_max = w_py;
            end
        end
    end

    assign w_nxt_found = (w_nxt_count >= CW'(MIN_COUNT));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= c_WAIT_SOF;
            r_any_red   <= 1'b0;
            r_count     <= '0;
            r_acc_x_min <= '0;
            r_acc_x_max <= '0;
            r_acc_y_min <= '0;
            r_acc_y_max <= '0;
            r_box_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_found     <= 1'b0;
            r_res_x_min <= '0;
            r_res_x_max <= '0;
            r_res_y_min <= '0;
            r_res_y_max <= '0;
            r_res_count <= '0;
        end else begin
            r_box_valid <= 1'b0;
            r_sync_err  <= w_sync_err;
            if (w_sof_beat) begin
                r_state <= c_ACCUM;
            end
            if (w_frame_end) begin
                r_box_valid <= 1'b1;
                r_found     <= w_nxt_found;
                r_res_count <= w_nxt_count;
                r_res_x_min <= w_nxt_found ? w_nxt_x_min : '0;
                r_res_x_max <= w_nxt_found ? w_nxt_x_max : '0;
                r_res_y_min <= w_nxt_found ? w_nxt_y_min : '0;
                r_res_y_max <= w_nxt_found ? w_nxt_y_max : '0;
                r_any_red   <= 1'b0;
                r_count     <= '0;
                r_acc_x_min <= '0;
                r_acc_x_max <= '0;
                r_acc_y_min <= '0;
                r_acc_y_max <= '0;
            end else if (w_proc) begin
                r_any_red   <= w_nxt_any;
                r_count     <= w_nxt_count;
                r_acc_x_min <= w_nxt_x_min;
                r_acc_x_max <= w_nxt_x_max;
                r_acc_y_min <= w_nxt_y_min;
                r_acc_y_max <= w_nxt_y_max;
            end
        end
    end

    assign o_box_valid = r_box_valid;
    assign o_sync_err  = r_sync_err;
    assign o_found     = r_found;
    assign o_x_min     = r_res_x_min;
    assign o_x_max     = r_res_x_max;
    assign o_y_min     = r_res_y_min;
    assign o_y_max     = r_res_y_max;
    assign o_red_count = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_pp_red_box_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_red_box_tracker
// Description : Scoreboard bench for pp_red_box_tracker on an 8x4 frame with
//               MIN_COUNT = 2. The reference model keeps each frame as a
//               bitmap indexed by pixel number. It computes the box from the
//               whole bitmap when the frame completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_red_box_tracker;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int MIN = 2;
    localparam int N   = H * V;
    localparam int XW  = 3;
    localparam int YW  = 2;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid = 1'b0;
    logic          red = 1'b0;
    logic          sof = 1'b0;
    logic          box_valid, found, sync_err;
    logic [XW-1:0] x_min, x_max;
    logic [YW-1:0] y_min, y_max;
    logic [CW-1:0] red_count;

    pp_red_box_tracker #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .MIN_COUNT (MIN)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_valid        (valid),
        .i_pixel_is_red (red),
        .i_sof          (sof),
        .o_box_valid    (box_valid),
        .o_found        (found),
        .o_x_min        (x_min),
        .o_x_max        (x_max),
        .o_y_min        (y_min),
        .o_y_max        (y_max),
        .o_red_count    (red_count),
        .o_sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int cyc;
        int found, xmin, xmax, ymin, ymax, count;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gap_pct = 0;

    // Reference model state
    bit   synced = 1'b0;
    int   idx = 0;
    bit   frame[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_beat(input bit r, input bit s);
        exp_t e;
        if (s && (!synced || idx != 0)) begin
            if (synced) begin
                e = '{is_err: 1'b1, cyc: cyc + 1, found: 0, xmin: 0, xmax: 0,
                      ymin: 0, ymax: 0, count: 0};
                q.push_back(e);
            end
            synced = 1'b1;
            idx = 0;
        end
        if (!synced) return;
        frame[idx] = r;
        idx++;
        if (idx == N) begin
            int cnt = 0, xmn = H, xmx = -1, ymn = V, ymx = -1;
            for (int i = 0; i < N; i++) begin
                if (frame[i]) begin
                    cnt++;
                    if (i % H < xmn) xmn = i % H;
                    if (i % H > xmx) xmx = i % H;
                    if (i / H < ymn) ymn = i / H;
                    if (i / H > ymx) ymx = i / H;
                end
            end
            e.is_err = 1'b0;
            e.cyc    = cyc + 1;
            e.count  = cnt;
            e.found  = (cnt >= MIN) ? 1 : 0;
            e.xmin   = e.found ? xmn : 0;
            e.xmax   = e.found ? xmx : 0;
            e.ymin   = e.found ? ymn : 0;
            e.ymax   = e.found ? ymx : 0;
            q.push_back(e);
            idx = 0;
        end
    endtask

    // Monitor: pops one expectation per output pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missing_pulse_at_cycle", 0, e.cyc);
        end
        if (rstn && (box_valid || sync_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse box_valid=%0b sync_err=%0b required none (cycle %0d)",
                         box_valid, sync_err, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("sync_err", int'(sync_err), int'(e.is_err));
                chk("box_valid", int'(box_valid), int'(!e.is_err));
                if (!e.is_err) begin
                    chk("found", int'(found), e.found);
                    chk("x_min", int'(x_min), e.xmin);
                    chk("x_max", int'(x_max), e.xmax);
                    chk("y_min", int'(y_min), e.ymin);
                    chk("y_max", int'(y_max), e.ymax);
                    chk("red_count", int'(red_count), e.count);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            red   = 1'($urandom);
            sof   = 1'($urandom);
        end
    endtask

    task automatic beat(input bit r, input bit s);
        while (int'($urandom_range(99)) < gap_pct) idle(1);
        @(posedge clk); #1;
        valid = 1'b1;
        red   = r;
        sof   = s;
        model_beat(r, s);
    endtask

    task automatic send_frame(input bit [N-1:0] mask);
        for (int i = 0; i < N; i++) beat(mask[i], i == 0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, int'({box_valid, found, x_min, x_max, y_min, y_max, red_count, sync_err}), 0);
    endtask

    initial begin
        bit [N-1:0] m;
        #2;
        chk_outputs_zero("reset_outputs");
        @(negedge clk); rstn = 1'b1;

        // Unsynchronised beats are ignored
        for (int i = 0; i < N; i++) beat(1'($urandom), 1'b0);
        idle(3);

        // Red at (2,1) and (5,3)
        m = '0; m[1*H+2] = 1'b1; m[3*H+5] = 1'b1;
        send_frame(m);
        idle(2);

        // Single red on the last pixel: below MIN_COUNT
        m = '0; m[N-1] = 1'b1;
        send_frame(m);
        idle(2);

        // Back-to-back frames with continuous valid
        gap_pct = 0;
        m = N'($urandom);
        send_frame(m);
        m = '0; m[0] = 1'b1; m[1] = 1'b1;
        send_frame(m);
        idle(2);

        // Full-red frame with random gaps
        gap_pct = 50;
        send_frame('1);
        idle(2);

        // Early sof at (3,2) aborts the frame
        gap_pct = 30;
        m = N'($urandom);
        for (int i = 0; i < 2*H+3; i++) beat(m[i], i == 0);
        send_frame(N'($urandom));
        idle(2);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 10; i++) beat(1'($urandom), i == 0);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midframe_reset_outputs");
        synced = 1'b0;
        idx = 0;
        q.delete();
        @(negedge clk); rstn = 1'b1;
        idle(1);
        for (int i = 0; i < N; i++) beat(1'($urandom), 1'b0);
        send_frame(N'($urandom));
        idle(2);

        // Random frames, occasionally with an injected early sof
        for (int f = 0; f < 6; f++) begin
            gap_pct = int'($urandom_range(40));
            m = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++)
                beat(m[i], i == 0 || ($urandom_range(60) == 0));
        end
        idle(6);

        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
